ps2_letter_decoder: RTL and testbench

Converts the raw PS/2 scan-code byte stream (set 2) from the keyboard receiver into the 5-bit letter codes the game datapath consumes on its `char` / `guess` inputs. It sits directly upstream of the datapath. It decodes make/break/extended prefixes, maps A–Z, Enter and Backspace, and buffers decoded codes in a 2-entry FIFO behind a valid/ready handshake so that no keystroke is lost while the control FSM is busy.

---
 rtl/ps2_letter_decoder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ps2_letter_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_letter_decoder.sv
// ps2_letter_decoder
// Turns the PS/2 set-2 scan-code byte stream into 5-bit letter codes
// (A-Z = 1..26, Enter = 27, Backspace = 28). It handles make, break and
// extended prefixes, tracks whether a mapped key is currently held, and
// queues decoded codes in a small first-word-fall-through FIFO behind a
// valid/ready handshake.
//
// Parameters:
//   FIFO_DEPTH - number of FIFO entries. Only 2 and 4 are meaningful.
//
// Build option:
//   PS2_TYPEMATIC_FILTER_EN - when defined, a make of the key that is
//   already held is suppressed. This filters keyboard auto-repeat. When
//   undefined, every make is queued. `held` tracking works either way.
//
// Reset: `resetn` is synchronous and asserted HIGH. The name is kept
// from the surrounding codebase.

module ps2_letter_decoder #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_en,
  output logic [4:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       overflow,
  output logic       held
);

  // ------------------------------------------------------------------
  // Constants and types
  // ------------------------------------------------------------------
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [7:0] BYTE_BREAK  = 8'hF0;
  localparam logic [7:0] BYTE_EXT    = 8'hE0;
  localparam logic [7:0] BYTE_ENTER  = 8'h5A;

  localparam logic [4:0] CODE_ENTER  = 5'd27;
  localparam logic [4:0] CODE_BKSP   = 5'd28;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  // ------------------------------------------------------------------
  // Non-extended scan-code map. Returns 0 for any unmapped byte,
  // including the prefix bytes themselves.
  // ------------------------------------------------------------------
  function automatic logic [4:0] map_scan(input logic [7:0] b);
    logic [4:0] c;
    case (b)
      8'h1C:   c = 5'd1;   // A
      8'h32:   c = 5'd2;   // B
      8'h21:   c = 5'd3;   // C
      8'h23:   c = 5'd4;   // D
      8'h24:   c = 5'd5;   // E
      8'h2B:   c = 5'd6;   // F
      8'h34:   c = 5'd7;   // G
      8'h33:   c = 5'd8;   // H
      8'h43:   c = 5'd9;   // I
      8'h3B:   c = 5'd10;  // J
      8'h42:   c = 5'd11;  // K
      8'h4B:   c = 5'd12;  // L
      8'h3A:   c = 5'd13;  // M
      8'h31:   c = 5'd14;  // N
      8'h44:   c = 5'd15;  // O
      8'h4D:   c = 5'd16;  // P
      8'h15:   c = 5'd17;  // Q
      8'h2D:   c = 5'd18;  // R
      8'h1B:   c = 5'd19;  // S
      8'h2C:   c = 5'd20;  // T
      8'h3C:   c = 5'd21;  // U
      8'h2A:   c = 5'd22;  // V
      8'h1D:   c = 5'd23;  // W
      8'h22:   c = 5'd24;  // X
      8'h35:   c = 5'd25;  // Y
      8'h1A:   c = 5'd26;  // Z
      8'h5A:   c = CODE_ENTER;
      8'h66:   c = CODE_BKSP;
      default: c = 5'd0;
    endcase
    return c;
  endfunction

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  state_t                      state_q, state_d;
  logic                        held_q, held_d;
  logic [4:0]                  held_code_q, held_code_d;
  logic                        overflow_q, overflow_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        valid_q, valid_d;
  logic [FIFO_DEPTH-1:0][4:0]  fifo_q, fifo_d;

  // Decoder events for the current strobe.
  logic [4:0] plain_code;
  logic       make_vld;
  logic [4:0] make_code;
  logic       brk_vld;
  logic [4:0] brk_code;

  // Push request after typematic filtering.
  logic       suppress;
  logic       push;
  logic [4:0] push_code;

  // FIFO control.
  logic             pop;
  logic             full;
  logic             push_acc;
  logic [CNT_W-1:0] wr_idx;

  // ------------------------------------------------------------------
  // Prefix FSM: classify each strobed byte as a make, a break or a
  // prefix, and pick the next prefix state.
  // ------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    make_vld   = 1'b0;
    make_code  = 5'd0;
    brk_vld    = 1'b0;
    brk_code   = 5'd0;
    plain_code = map_scan(ps2_byte);

    if (ps2_byte_en) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_byte == BYTE_BREAK) begin
            state_d = ST_BRK;
          end else if (ps2_byte == BYTE_EXT) begin
            state_d = ST_EXT;
          end else if (plain_code != 5'd0) begin
            make_vld  = 1'b1;
            make_code = plain_code;
          end
        end

        ST_EXT: begin
          if (ps2_byte == BYTE_BREAK) begin
            state_d = ST_EXT_BRK;
          end else begin
            // Keypad Enter is the only extended key we care about.
            state_d = ST_IDLE;
            if (ps2_byte == BYTE_ENTER) begin
              make_vld  = 1'b1;
              make_code = CODE_ENTER;
            end
          end
        end

        ST_BRK: begin
          // Whatever follows F0 is the released key. A second prefix byte
          // is simply an unmapped key here.
          state_d  = ST_IDLE;
          brk_vld  = (plain_code != 5'd0);
          brk_code = plain_code;
        end

        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (ps2_byte == BYTE_ENTER) begin
            brk_vld  = 1'b1;
            brk_code = CODE_ENTER;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Typematic filter: optionally suppress a repeat make of the held key.
  // ------------------------------------------------------------------
`ifdef PS2_TYPEMATIC_FILTER_EN
  assign suppress = held_q && (make_code == held_code_q);
`else
  assign suppress = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Held-key tracking and FIFO push request.
  // ------------------------------------------------------------------
  always_comb begin
    held_d      = held_q;
    held_code_d = held_code_q;
    push        = 1'b0;
    push_code   = make_code;

    if (make_vld) begin
      // Any mapped make, even a suppressed or dropped one, marks the key
      // as held.
      held_d      = 1'b1;
      held_code_d = make_code;
      push        = !suppress;
    end else if (brk_vld && held_q && (brk_code == held_code_q)) begin
      // Only the release of the key we think is held clears `held`.
      held_d = 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // FIFO bookkeeping. Entry 0 is always the head; unused entries are
  // kept at zero so `code` reads 0 while the FIFO is empty.
  // ------------------------------------------------------------------
  always_comb begin
    pop        = valid_q & code_ready;
    full       = (count_q == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees a slot even when full.
    push_acc   = push & (!full | pop);
    overflow_d = overflow_q | (push & full & !pop);
    count_d    = count_q + CNT_W'(push_acc) - CNT_W'(pop);
    wr_idx     = count_q - CNT_W'(pop);
    valid_d    = (count_d != '0);
  end

  // Per-entry next value: shift toward the head on a pop, then write the
  // pushed code into the first free slot.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [4:0] shifted;

      if (gi == FIFO_DEPTH - 1) begin : g_top
        assign shifted = pop ? 5'd0 : fifo_q[gi];
      end else begin : g_mid
        assign shifted = pop ? fifo_q[gi+1] : fifo_q[gi];
      end

      assign fifo_d[gi] = (push_acc && (wr_idx == CNT_W'(gi))) ? push_code : shifted;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Register update for the FSM, held tracking and FIFO.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= ST_IDLE;
      held_q      <= 1'b0;
      held_code_q <= 5'd0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      fifo_q      <= '0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      held_code_q <= held_code_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      fifo_q      <= fifo_d;
    end
  end

  // Outputs come straight from registers.
  assign code       = fifo_q[0];
  assign code_valid = valid_q;
  assign overflow   = overflow_q;
  assign held       = held_q;

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Directed bench for ps2_letter_decoder: a table of one-cycle vectors
// followed by hand-written sequences for FIFO full push/pop, reset in the
// middle of a prefix, and typematic repeats.
`timescale 1ns/1ps

module tb_ps2_letter_decoder;

  logic       clk;
  logic       resetn;
  logic [7:0] ps2_byte;
  logic       ps2_byte_en;
  logic [4:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       overflow;
  logic       held;

  int checks = 0;
  int errors = 0;

  ps2_letter_decoder #(.FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ps2_byte    (ps2_byte),
    .ps2_byte_en (ps2_byte_en),
    .code        (code),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .overflow    (overflow),
    .held        (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       en;
    logic       rdy;
    logic [4:0] exp_code;
    logic       exp_valid;
    logic       exp_ovf;
    logic       exp_held;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [7:0] b, input logic en, input logic rdy,
                              input logic [4:0] c, input logic v, input logic o,
                              input logic h);
    vec_t r;
    r.b = b; r.en = en; r.rdy = rdy;
    r.exp_code = c; r.exp_valid = v; r.exp_ovf = o; r.exp_held = h;
    tbl.push_back(r);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_outs(input string name, input int c, input int v,
                            input int o, input int h);
    check({name, " code"},     int'(code),       c);
    check({name, " valid"},    int'(code_valid), v);
    check({name, " overflow"}, int'(overflow),   o);
    check({name, " held"},     int'(held),       h);
  endtask

  // One clock: drive on the falling edge, return 1 ns after the rising edge.
  task automatic step(input logic [7:0] b, input logic en, input logic rdy,
                      input logic rst = 1'b0);
    @(negedge clk);
    ps2_byte    = b;
    ps2_byte_en = en;
    code_ready  = rdy;
    resetn      = rst;
    @(posedge clk);
    #1;
  endtask

  int pulses;

  initial begin
    resetn      = 1'b1;
    ps2_byte    = 8'h00;
    ps2_byte_en = 1'b0;
    code_ready  = 1'b0;

    //        byte   en rdy code v ovf held
    // Plain make/break of A with consumer ready.
    add(8'h1C, 1, 1, 5'd1,  1, 0, 1);  // 0
    add(8'h00, 0, 1, 5'd0,  0, 0, 1);  // 1 popped
    add(8'hF0, 1, 1, 5'd0,  0, 0, 1);  // 2
    add(8'h1C, 1, 1, 5'd0,  0, 0, 0);  // 3 break clears held
    // Extended Enter make/break, then plain Enter.
    add(8'hE0, 1, 0, 5'd0,  0, 0, 0);  // 4
    add(8'h5A, 1, 0, 5'd27, 1, 0, 1);  // 5
    add(8'hE0, 1, 0, 5'd27, 1, 0, 1);  // 6
    add(8'hF0, 1, 0, 5'd27, 1, 0, 1);  // 7
    add(8'h5A, 1, 0, 5'd27, 1, 0, 0);  // 8 extended break
    add(8'h5A, 1, 0, 5'd27, 1, 0, 1);  // 9 second 27 queued
    add(8'hF0, 1, 1, 5'd27, 1, 0, 1);  // 10 pop first 27
    add(8'h5A, 1, 1, 5'd0,  0, 0, 0);  // 11 pop second 27
    // E0 1C is ignored, FSM back in IDLE.
    add(8'hE0, 1, 0, 5'd0,  0, 0, 0);  // 12
    add(8'h1C, 1, 0, 5'd0,  0, 0, 0);  // 13
    add(8'h1C, 1, 0, 5'd1,  1, 0, 1);  // 14 plain A now decodes
    add(8'h00, 0, 1, 5'd0,  0, 0, 1);  // 15
    add(8'hF0, 1, 0, 5'd0,  0, 0, 1);  // 16
    add(8'h1C, 1, 0, 5'd0,  0, 0, 0);  // 17
    // Q, R, S with consumer stalled: S overflows.
    add(8'h15, 1, 0, 5'd17, 1, 0, 1);  // 18
    add(8'hF0, 1, 0, 5'd17, 1, 0, 1);  // 19
    add(8'h15, 1, 0, 5'd17, 1, 0, 0);  // 20
    add(8'h2D, 1, 0, 5'd17, 1, 0, 1);  // 21
    add(8'hF0, 1, 0, 5'd17, 1, 0, 1);  // 22
    add(8'h2D, 1, 0, 5'd17, 1, 0, 0);  // 23
    add(8'h1B, 1, 0, 5'd17, 1, 1, 1);  // 24 dropped
    add(8'hF0, 1, 0, 5'd17, 1, 1, 1);  // 25
    add(8'h1B, 1, 0, 5'd17, 1, 1, 0);  // 26
    add(8'h00, 0, 1, 5'd18, 1, 1, 0);  // 27
    add(8'h00, 0, 1, 5'd0,  0, 1, 0);  // 28
    // Backspace, Z, break of another key, unmapped byte.
    add(8'h66, 1, 1, 5'd28, 1, 1, 1);  // 29 ready ignored while empty
    add(8'hF0, 1, 1, 5'd0,  0, 1, 1);  // 30
    add(8'h66, 1, 1, 5'd0,  0, 1, 0);  // 31
    add(8'h1A, 1, 0, 5'd26, 1, 1, 1);  // 32
    add(8'hF0, 1, 1, 5'd0,  0, 1, 1);  // 33
    add(8'h32, 1, 1, 5'd0,  0, 1, 1);  // 34 break of B keeps held
    add(8'hF0, 1, 1, 5'd0,  0, 1, 1);  // 35
    add(8'h1A, 1, 1, 5'd0,  0, 1, 0);  // 36
    add(8'h29, 1, 1, 5'd0,  0, 1, 0);  // 37 unmapped

    // Reset state.
    step(8'h00, 0, 0, 1'b1);
    step(8'h00, 0, 0, 1'b1);
    check_outs("reset", 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].b, tbl[i].en, tbl[i].rdy);
      $display("vec %0d byte %02h en %0b rdy %0b -> code %0d valid %0b ovf %0b held %0b",
               i, tbl[i].b, tbl[i].en, tbl[i].rdy, code, code_valid, overflow, held);
      check_outs($sformatf("vec%0d", i), tbl[i].exp_code, tbl[i].exp_valid,
                 tbl[i].exp_ovf, tbl[i].exp_held);
    end

    // Reset with a queued code, overflow set, held set and E0 pending.
    step(8'h1C, 1, 0);
    step(8'hE0, 1, 0);
    step(8'h00, 0, 0, 1'b1);
    $display("reset mid-prefix -> code %0d valid %0b ovf %0b held %0b", code, code_valid, overflow, held);
    check_outs("rst_mid", 0, 0, 0, 0);
    step(8'h1C, 1, 0);
    $display("post-reset A -> code %0d valid %0b", code, code_valid);
    check_outs("rst_then_A", 1, 1, 0, 1);
    step(8'h00, 0, 1);
    step(8'hE0, 1, 0);
    step(8'h00, 0, 0, 1'b1);
    check("rst_E0 valid", int'(code_valid), 0);
    step(8'h5A, 1, 0);
    $display("post-reset Enter -> code %0d valid %0b", code, code_valid);
    check_outs("rst_then_5A", 27, 1, 0, 1);

    // Full FIFO with simultaneous push and pop.
    step(8'h00, 0, 0, 1'b1);
    step(8'h1C, 1, 0);
    step(8'hF0, 1, 0);
    step(8'h1C, 1, 0);
    step(8'h32, 1, 0);
    step(8'hF0, 1, 0);
    step(8'h32, 1, 0);
    check_outs("full", 1, 1, 0, 0);
    step(8'h21, 1, 1);
    $display("full push+pop -> code %0d valid %0b ovf %0b", code, code_valid, overflow);
    check_outs("full_pushpop", 2, 1, 0, 1);
    step(8'h00, 0, 1);
    check_outs("drain1", 3, 1, 0, 1);
    step(8'h00, 0, 1);
    check_outs("drain2", 0, 0, 0, 1);

    // Typematic repeats: A A A, break A, A.
    step(8'h00, 0, 0, 1'b1);
    pulses = 0;
    begin
      logic [7:0] seq [6];
      seq[0] = 8'h1C; seq[1] = 8'h1C; seq[2] = 8'h1C;
      seq[3] = 8'hF0; seq[4] = 8'h1C; seq[5] = 8'h1C;
      for (int k = 0; k < 6; k++) begin
        step(seq[k], 1, 1);
        if (code_valid && code == 5'd1) pulses++;
        for (int j = 0; j < 2; j++) begin
          step(8'h00, 0, 1);
          if (code_valid && code == 5'd1) pulses++;
        end
      end
    end
    $display("typematic -> %0d codes accepted", pulses);
`ifdef PS2_TYPEMATIC_FILTER_EN
    check("typematic pushes", pulses, 2);
`else
    check("typematic pushes", pulses, 4);
`endif
    check("typematic held", int'(held), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
